// File: rtl/display_pkg.sv
// Shared seven-segment definitions for the Go Board displays.
// Patterns are active-low with segment A in bit 6 down to segment G in bit 0.
package display_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h7E;

  localparam logic [6:0] SEG_DIGIT_0 = 7'h01;
  localparam logic [6:0] SEG_DIGIT_1 = 7'h4F;
  localparam logic [6:0] SEG_DIGIT_2 = 7'h12;
  localparam logic [6:0] SEG_DIGIT_3 = 7'h06;
  localparam logic [6:0] SEG_DIGIT_4 = 7'h4C;
  localparam logic [6:0] SEG_DIGIT_5 = 7'h24;
  localparam logic [6:0] SEG_DIGIT_6 = 7'h20;
  localparam logic [6:0] SEG_DIGIT_7 = 7'h0F;
  localparam logic [6:0] SEG_DIGIT_8 = 7'h00;
  localparam logic [6:0] SEG_DIGIT_9 = 7'h04;

endpackage

// File: rtl/seven_seg_encoder.sv
// Combinational BCD to active-low seven-segment encoder; codes 10-15 show a dash.
module seven_seg_encoder
  import display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] segments
);

  always_comb begin
    segments = SEG_DASH;
    case (digit)
      4'd0:    segments = SEG_DIGIT_0;
      4'd1:    segments = SEG_DIGIT_1;
      4'd2:    segments = SEG_DIGIT_2;
      4'd3:    segments = SEG_DIGIT_3;
      4'd4:    segments = SEG_DIGIT_4;
      4'd5:    segments = SEG_DIGIT_5;
      4'd6:    segments = SEG_DIGIT_6;
      4'd7:    segments = SEG_DIGIT_7;
      4'd8:    segments = SEG_DIGIT_8;
      4'd9:    segments = SEG_DIGIT_9;
      default: segments = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seconds_display.sv
// Extends an upstream 0-9 seconds digit to 00-59, drives both displays with
// leading-zero blanking and PWM dimming, and pulses once per minute.
module seconds_display
  import display_pkg::*;
#(
  parameter int BLANK_LEADING = 1,
  parameter int TENS_MAX      = 5
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [3:0] i_Count,
  input  logic       i_Clear,
  input  logic [3:0] i_Bright,
  output logic [6:0] o_Segment1,
  output logic [6:0] o_Segment2,
  output logic       o_Minute
);

  localparam logic [3:0] TENS_LAST = 4'(TENS_MAX);

  logic [3:0] r_Units;
  logic [3:0] r_Tens;
  logic [3:0] r_Pwm;
  logic       w_Wrap;
  logic       w_Enable;
  logic       w_Blank_Tens;
  logic [6:0] w_Units_Seg;
  logic [6:0] w_Tens_Seg;

  // r_Units doubles as the previous sample, so only a true 9->0 step counts.
  assign w_Wrap       = (r_Units == 4'd9) && (i_Count == 4'd0);
  assign w_Enable     = (r_Pwm < i_Bright) || (i_Bright == 4'd15);
  assign w_Blank_Tens = (BLANK_LEADING != 0) && (r_Tens == 4'd0);

  seven_seg_encoder u_units_enc (
    .digit    (r_Units),
    .segments (w_Units_Seg)
  );

  seven_seg_encoder u_tens_enc (
    .digit    (r_Tens),
    .segments (w_Tens_Seg)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Units    <= 4'd0;
      r_Tens     <= 4'd0;
      r_Pwm      <= 4'd0;
      o_Minute   <= 1'b0;
      o_Segment1 <= SEG_BLANK;
      o_Segment2 <= SEG_BLANK;
    end else begin
      r_Units  <= i_Count;
      r_Pwm    <= r_Pwm + 4'd1;
      o_Minute <= 1'b0;

      // Clear wins over a coincident wrap, suppressing the minute pulse too.
      if (i_Clear) begin
        r_Tens <= 4'd0;
      end else if (w_Wrap) begin
        if (r_Tens < TENS_LAST) begin
          r_Tens <= r_Tens + 4'd1;
        end else begin
          r_Tens   <= 4'd0;
          o_Minute <= 1'b1;
        end
      end

      o_Segment2 <= w_Enable ? w_Units_Seg : SEG_BLANK;
      o_Segment1 <= (w_Enable && !w_Blank_Tens) ? w_Tens_Seg : SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_seconds_display.sv
// Scoreboard bench: the driver predicts each edge's outputs from a seconds model,
// a monitor compares them one cycle at a time.
module tb_seconds_display;

  typedef struct {
    logic [6:0] s1;
    logic [6:0] s2;
    logic       m;
  } exp_t;

  logic       clk;
  logic       i_Rst;
  logic [3:0] i_Count;
  logic       i_Clear;
  logic [3:0] i_Bright;
  logic [6:0] o_Segment1;
  logic [6:0] o_Segment2;
  logic       o_Minute;

  int errors = 0;
  int checks = 0;
  int minutes_seen = 0;
  exp_t exp_q[$];

  // Reference model: seconds tens digit, last units digit, PWM phase.
  int m_units;
  int m_tens;
  int m_phase;
  logic [6:0] digit_pat [0:9] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                                  7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};

  seconds_display dut (
    .i_Clk      (clk),
    .i_Rst      (i_Rst),
    .i_Count    (i_Count),
    .i_Clear    (i_Clear),
    .i_Bright   (i_Bright),
    .o_Segment1 (o_Segment1),
    .o_Segment2 (o_Segment2),
    .o_Minute   (o_Minute)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] pattern(input int d);
    if (d >= 0 && d <= 9) return digit_pat[d];
    return 7'h7E;
  endfunction

  // Drive one cycle of inputs, predict the outputs after the next edge, advance the model.
  task automatic step(input logic rst, input logic [3:0] cnt, input logic clr, input logic [3:0] br);
    exp_t e;
    bit lit;
    bit wrap;
    i_Rst    = rst;
    i_Count  = cnt;
    i_Clear  = clr;
    i_Bright = br;
    lit  = (br == 4'd15) || (m_phase < int'(br));
    wrap = (m_units == 9) && (cnt == 4'd0);
    if (rst) begin
      e.s1 = 7'h7F;
      e.s2 = 7'h7F;
      e.m  = 1'b0;
      m_units = 0;
      m_tens  = 0;
      m_phase = 0;
    end else begin
      e.s2 = lit ? pattern(m_units) : 7'h7F;
      e.s1 = (lit && m_tens != 0) ? pattern(m_tens) : 7'h7F;
      e.m  = !clr && wrap && (m_tens == 5);
      if (clr) m_tens = 0;
      else if (wrap) m_tens = (m_tens + 1) % 6;
      m_units = int'(cnt);
      m_phase = (m_phase + 1) % 16;
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    logic prev_min;
    exp_t e;
    prev_min = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("seg1", 32'(o_Segment1), 32'(e.s1));
        check("seg2", 32'(o_Segment2), 32'(e.s2));
        check("minute", 32'(o_Minute), 32'(e.m));
      end
      if (o_Minute === 1'b1) begin
        minutes_seen++;
        check("minute_width", 32'(prev_min), 32'd0);
      end
      prev_min = o_Minute;
    end
  end

  initial begin : driver
    int base;
    int lit_cnt;
    int cur;
    logic [3:0] br;
    logic [3:0] nxt;
    m_units = 0; m_tens = 0; m_phase = 0;

    // Reset with a 7 waiting upstream.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'd7, 1'b0, 4'd15);
      check("reset_seg1", 32'(o_Segment1), 32'h7F);
      check("reset_seg2", 32'(o_Segment2), 32'h7F);
      check("reset_minute", 32'(o_Minute), 32'd0);
    end
    step(1'b0, 4'd7, 1'b0, 4'd15);
    step(1'b0, 4'd7, 1'b0, 4'd15);
    check("post_reset_seg2", 32'(o_Segment2), 32'h0F);
    check("post_reset_seg1_blank", 32'(o_Segment1), 32'h7F);

    // Tens advance on 8,9,0.
    step(1'b0, 4'd8, 1'b0, 4'd15);
    step(1'b0, 4'd9, 1'b0, 4'd15);
    step(1'b0, 4'd0, 1'b0, 4'd15);
    step(1'b0, 4'd0, 1'b0, 4'd15);
    check("tens1_seg1", 32'(o_Segment1), 32'h4F);
    check("tens1_seg2", 32'(o_Segment2), 32'h01);

    // One full minute (six 0..9 runs plus the closing 0) from a cleared tens.
    step(1'b0, 4'd0, 1'b1, 4'd15);
    base = minutes_seen;
    for (int s = 0; s < 6; s++)
      for (int d = 0; d < 10; d++) step(1'b0, 4'(d), 1'b0, 4'd15);
    step(1'b0, 4'd0, 1'b0, 4'd15);
    step(1'b0, 4'd0, 1'b0, 4'd15);
    check("minute_count", 32'(minutes_seen - base), 32'd1);
    check("minute_seg1_blank", 32'(o_Segment1), 32'h7F);

    // Invalid digit, then 0: dash, no tens advance.
    base = minutes_seen;
    step(1'b0, 4'd12, 1'b0, 4'd15);
    step(1'b0, 4'd0, 1'b0, 4'd15);
    check("invalid_dash", 32'(o_Segment2), 32'h7E);
    step(1'b0, 4'd0, 1'b0, 4'd15);
    check("invalid_then_zero", 32'(o_Segment2), 32'h01);
    check("invalid_tens_unchanged", 32'(o_Segment1), 32'h7F);
    check("invalid_no_minute", 32'(minutes_seen - base), 32'd0);

    // Brightness duty over 32 cycles.
    for (int k = 0; k < 3; k++) begin
      br = (k == 0) ? 4'd4 : (k == 1) ? 4'd0 : 4'd15;
      lit_cnt = 0;
      for (int i = 0; i < 32; i++) begin
        step(1'b0, 4'd3, 1'b0, br);
        if (o_Segment2 !== 7'h7F) lit_cnt++;
      end
      check($sformatf("bright_%0d_lit", br), 32'(lit_cnt), (k == 0) ? 32'd8 : (k == 1) ? 32'd0 : 32'd32);
    end

    // Clear coinciding with the minute wrap at tens=5.
    step(1'b0, 4'd0, 1'b1, 4'd15);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'd9, 1'b0, 4'd15);
      step(1'b0, 4'd0, 1'b0, 4'd15);
    end
    step(1'b0, 4'd9, 1'b0, 4'd15);
    check("tens5_seg1", 32'(o_Segment1), 32'h24);
    base = minutes_seen;
    step(1'b0, 4'd0, 1'b1, 4'd15);
    step(1'b0, 4'd0, 1'b0, 4'd15);
    check("clear_no_minute", 32'(minutes_seen - base), 32'd0);
    check("clear_seg1_blank", 32'(o_Segment1), 32'h7F);

    // Reset in the middle of a run at tens=3.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'd9, 1'b0, 4'd15);
      step(1'b0, 4'd0, 1'b0, 4'd15);
    end
    step(1'b0, 4'd5, 1'b0, 4'd15);
    check("tens3_seg1", 32'(o_Segment1), 32'h06);
    step(1'b1, 4'd6, 1'b0, 4'd15);
    check("midreset_seg1", 32'(o_Segment1), 32'h7F);
    check("midreset_seg2", 32'(o_Segment2), 32'h7F);
    step(1'b0, 4'd0, 1'b0, 4'd15);
    step(1'b0, 4'd0, 1'b0, 4'd15);
    check("midreset_tens_blank", 32'(o_Segment1), 32'h7F);

    // Randomised run: mostly counting, with jumps, invalid codes, clears, resets, dimming.
    cur = 0;
    br  = 4'd15;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) nxt = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 2) == 0) nxt = 4'(cur);
      else nxt = 4'((cur + 1) % 10);
      cur = (nxt > 4'd9) ? 0 : int'(nxt);
      if ($urandom_range(0, 39) == 0) br = 4'($urandom_range(0, 15));
      step($urandom_range(0, 299) == 0, nxt, $urandom_range(0, 59) == 0, br);
    end

    step(1'b0, 4'd0, 1'b0, 4'd15);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
